fg_dac_write_if: RTL

//  Downstream stage of the function generator core: consumes (sample, valid) pairs and drives the parallel DAC.

---
 rtl/fg_dac_write_if.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/fg_dac_write_if.sv
// Buffers generator samples in a FIFO and replays each as a timed DAC write (setup, active-low WR pulse, hold).
// Optional FG_DAC_DROP_CNT_EN adds a saturating dropped-sample counter; pushes while full are dropped, never stalled downstream.
module fg_dac_write_if #(
  parameter int BITWIDTH     = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int SETUP_CYCLES = 1,
  parameter int PULSE_CYCLES = 2,
  parameter int HOLD_CYCLES  = 1
`ifdef FG_DAC_DROP_CNT_EN
  , parameter int DROP_CNT_W = 8
`endif
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [BITWIDTH-1:0] data_i,
  input  logic                valid_i,
  output logic                ready_o,
  output logic [BITWIDTH-1:0] dac_data_o,
  output logic                dac_wr_n_o,
  output logic                dac_clr_n_o,
  output logic                busy_o,
  output logic                overflow_o
`ifdef FG_DAC_DROP_CNT_EN
  , output logic [DROP_CNT_W-1:0] drop_cnt_o
`endif
);

  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int MAXC = (SETUP_CYCLES > PULSE_CYCLES)
                        ? ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES)
                        : ((PULSE_CYCLES > HOLD_CYCLES) ? PULSE_CYCLES : HOLD_CYCLES);
  localparam int CW   = $clog2(MAXC) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_PULSE = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [BITWIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW:0]         count;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic [1:0]          state;
  logic [CW-1:0]       cnt;

  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign ready_o = !full;
  // A full FIFO rejects the push even when the FSM frees a slot on the same edge.
  assign push    = valid_i && !full;
  assign pop     = (state == S_IDLE) && !empty;
  assign busy_o  = (state != S_IDLE) || !empty;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Each phase counter is loaded with N-1 on entry and the phase ends when it reaches zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      cnt        <= '0;
      dac_data_o <= '0;
      dac_wr_n_o <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          dac_wr_n_o <= 1'b1;
          if (pop) begin
            state      <= S_SETUP;
            cnt        <= CW'(SETUP_CYCLES - 1);
            dac_data_o <= mem[rd_ptr];
          end
        end
        S_SETUP: begin
          if (cnt == '0) begin
            state      <= S_PULSE;
            cnt        <= CW'(PULSE_CYCLES - 1);
            dac_wr_n_o <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_PULSE: begin
          if (cnt == '0) begin
            state      <= S_HOLD;
            cnt        <= CW'(HOLD_CYCLES - 1);
            dac_wr_n_o <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_HOLD: begin
          if (cnt == '0) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state      <= S_IDLE;
          dac_wr_n_o <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dac_clr_n_o <= 1'b0;
    end else begin
      dac_clr_n_o <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overflow_o <= 1'b0;
    end else if (valid_i && full) begin
      overflow_o <= 1'b1;
    end
  end

`ifdef FG_DAC_DROP_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drop_cnt_o <= '0;
    end else if (valid_i && full && (drop_cnt_o != '1)) begin
      drop_cnt_o <= drop_cnt_o + 1'b1;
    end
  end
`endif

endmodule
